// File: rtl/mem_req_port_if.sv
// Cache <-> memory-controller packet bundle for mem_req_port.
// The master side is the environment (cache plus controller) and the slave side is the port itself.
interface mem_req_port_if #(
  parameter int unsigned DEPTH = 512
);
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [35:0]      req_addr;
  logic [DEPTH-1:0] req_data;
  logic [3:0]       req_id;
  logic [3:0]       pkt_id_out;
  logic [2:0]       pkt_type_out;
  logic [35:0]      pkt_addr_out;
  logic [DEPTH-1:0] pkt_data_out;
  logic [3:0]       pkt_id_in;
  logic [2:0]       pkt_type_in;
  logic [35:0]      pkt_addr_in;
  logic [DEPTH-1:0] pkt_data_in;
  logic             resp_valid;
  logic             resp_we;
  logic [3:0]       resp_id;
  logic [1:0]       resp_beat;
  logic [35:0]      resp_addr;
  logic [DEPTH-1:0] resp_data;
  logic [4:0]       outstanding;
  logic             err;

  modport master (
    output req_valid, req_we, req_addr, req_data,
    output pkt_id_in, pkt_type_in, pkt_addr_in, pkt_data_in,
    input  req_ready, req_id, pkt_id_out, pkt_type_out, pkt_addr_out, pkt_data_out,
    input  resp_valid, resp_we, resp_id, resp_beat, resp_addr, resp_data, outstanding, err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_data,
    input  pkt_id_in, pkt_type_in, pkt_addr_in, pkt_data_in,
    output req_ready, req_id, pkt_id_out, pkt_type_out, pkt_addr_out, pkt_data_out,
    output resp_valid, resp_we, resp_id, resp_beat, resp_addr, resp_data, outstanding, err
  );
endinterface

// File: rtl/mem_req_port.sv
// Requester endpoint: allocates in-order 4-bit request IDs, emits request packets and matches
// returning ack/read-data packets against the ID table.
module mem_req_port #(
  parameter int unsigned DEPTH = 512
) (
  input logic           clk,
  input logic           rst,
  mem_req_port_if.slave bus
);
  localparam bit         MultiBeat = (DEPTH != 512);
  localparam logic [2:0] PktWr     = 3'b001;
  localparam logic [2:0] PktRd     = 3'b011;
  localparam logic [2:0] RspAck    = 3'b101;
  localparam logic [2:0] RspRd     = 3'b110;

  logic [15:0]      busy_q, busy_d, we_q, we_d;
  logic [35:0]      addr_q [16];
  logic [35:0]      addr_d [16];
  logic [1:0]       beat_q [16];
  logic [1:0]       beat_d [16];
  logic [3:0]       next_id_q, next_id_d;
  logic [3:0]       pkt_id_q, pkt_id_d;
  logic [2:0]       pkt_type_q, pkt_type_d;
  logic [35:0]      pkt_addr_q, pkt_addr_d;
  logic [DEPTH-1:0] pkt_data_q, pkt_data_d;
  logic             resp_valid_q, resp_valid_d, resp_we_q, resp_we_d;
  logic [3:0]       resp_id_q, resp_id_d;
  logic [1:0]       resp_beat_q, resp_beat_d;
  logic [35:0]      resp_addr_q, resp_addr_d;
  logic [DEPTH-1:0] resp_data_q, resp_data_d;
  logic             err_q, err_d;
  logic             accept, is_ack, is_rd, hit, last_beat, free;
  logic [3:0]       rid;
  logic [4:0]       count;

  always_comb begin
    count = '0;
    for (int i = 0; i < 16; i++) count = count + 5'(busy_q[i]);
  end

  assign bus.req_ready    = ~busy_q[next_id_q];
  assign bus.req_id       = next_id_q;
  assign bus.outstanding  = count;
  assign bus.pkt_id_out   = pkt_id_q;
  assign bus.pkt_type_out = pkt_type_q;
  assign bus.pkt_addr_out = pkt_addr_q;
  assign bus.pkt_data_out = pkt_data_q;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_we      = resp_we_q;
  assign bus.resp_id      = resp_id_q;
  assign bus.resp_beat    = resp_beat_q;
  assign bus.resp_addr    = resp_addr_q;
  assign bus.resp_data    = resp_data_q;
  assign bus.err          = err_q;

  always_comb begin
    rid       = bus.pkt_id_in;
    accept    = bus.req_valid & ~busy_q[next_id_q];
    is_ack    = (bus.pkt_type_in == RspAck);
    is_rd     = (bus.pkt_type_in == RspRd);
    hit       = busy_q[rid] & ((is_ack & we_q[rid]) | (is_rd & ~we_q[rid]));
    last_beat = !MultiBeat || (beat_q[rid] == 2'd3);
    free      = hit & (is_ack | last_beat);

    busy_d       = busy_q;
    we_d         = we_q;
    addr_d       = addr_q;
    beat_d       = beat_q;
    next_id_d    = next_id_q;
    err_d        = err_q;
    pkt_id_d     = '0;
    pkt_type_d   = '0;
    pkt_addr_d   = '0;
    pkt_data_d   = '0;
    resp_valid_d = 1'b0;
    resp_we_d    = 1'b0;
    resp_id_d    = '0;
    resp_beat_d  = '0;
    resp_addr_d  = '0;
    resp_data_d  = '0;

    if (accept) begin
      busy_d[next_id_q] = 1'b1;
      we_d[next_id_q]   = bus.req_we;
      addr_d[next_id_q] = bus.req_addr;
      next_id_d         = next_id_q + 4'd1;
      pkt_id_d          = next_id_q;
      pkt_type_d        = bus.req_we ? PktWr : PktRd;
      pkt_addr_d        = bus.req_addr;
      pkt_data_d        = bus.req_data;
    end

    // Accepted IDs are never busy and matched IDs always are, so these updates never collide.
    if (hit) begin
      resp_valid_d = 1'b1;
      resp_we_d    = is_ack;
      resp_id_d    = rid;
      resp_addr_d  = addr_q[rid];
      resp_data_d  = is_rd ? bus.pkt_data_in : '0;
      resp_beat_d  = is_rd ? beat_q[rid] : 2'd0;
      // 2-bit counter wraps to 0 on the final beat, leaving the ID clean for reuse.
      if (is_rd && MultiBeat) beat_d[rid] = beat_q[rid] + 2'd1;
    end
    if (free) busy_d[rid] = 1'b0;
    if ((is_ack | is_rd) & ~hit) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q       <= '0;
      we_q         <= '0;
      for (int i = 0; i < 16; i++) begin
        addr_q[i] <= '0;
        beat_q[i] <= '0;
      end
      next_id_q    <= '0;
      err_q        <= 1'b0;
      pkt_id_q     <= '0;
      pkt_type_q   <= '0;
      pkt_addr_q   <= '0;
      pkt_data_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_we_q    <= 1'b0;
      resp_id_q    <= '0;
      resp_beat_q  <= '0;
      resp_addr_q  <= '0;
      resp_data_q  <= '0;
    end else begin
      busy_q       <= busy_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      beat_q       <= beat_d;
      next_id_q    <= next_id_d;
      err_q        <= err_d;
      pkt_id_q     <= pkt_id_d;
      pkt_type_q   <= pkt_type_d;
      pkt_addr_q   <= pkt_addr_d;
      pkt_data_q   <= pkt_data_d;
      resp_valid_q <= resp_valid_d;
      resp_we_q    <= resp_we_d;
      resp_id_q    <= resp_id_d;
      resp_beat_q  <= resp_beat_d;
      resp_addr_q  <= resp_addr_d;
      resp_data_q  <= resp_data_d;
    end
  end
endmodule

// File: tb/tb_mem_req_port.sv
// Self-checking bench for mem_req_port: directed scenarios on a full-line (512) and a
// quarter-line (128) instance, then a randomized run against a table-level reference model.
module tb_mem_req_port;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mem_req_port_if #(.DEPTH(512)) a_if ();
  mem_req_port_if #(.DEPTH(128)) b_if ();

  mem_req_port #(.DEPTH(512)) dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));
  mem_req_port #(.DEPTH(128)) dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));

  task automatic drive_a(input logic v, input logic we, input logic [35:0] addr,
                         input logic [511:0] data, input logic [2:0] rt, input logic [3:0] rid,
                         input logic [511:0] rdata);
    a_if.req_valid   = v;
    a_if.req_we      = we;
    a_if.req_addr    = addr;
    a_if.req_data    = data;
    a_if.pkt_type_in = rt;
    a_if.pkt_id_in   = rid;
    a_if.pkt_addr_in = '0;
    a_if.pkt_data_in = rdata;
    #1;
  endtask

  task automatic drive_b(input logic v, input logic [35:0] addr, input logic [2:0] rt,
                         input logic [3:0] rid, input logic [127:0] rdata);
    b_if.req_valid   = v;
    b_if.req_we      = 1'b0;
    b_if.req_addr    = addr;
    b_if.req_data    = '0;
    b_if.pkt_type_in = rt;
    b_if.pkt_id_in   = rid;
    b_if.pkt_addr_in = '0;
    b_if.pkt_data_in = rdata;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive_a(0, 0, '0, '0, 3'b000, '0, '0);
    drive_b(0, '0, 3'b000, '0, '0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 6;
    if (a_if.outstanding !== 5'd0) begin errors++; $display("FAIL reset_outstanding: got %0d exp 0", a_if.outstanding); end
    if (a_if.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b exp 1", a_if.req_ready); end
    if (a_if.req_id !== 4'd0) begin errors++; $display("FAIL reset_req_id: got %0d exp 0", a_if.req_id); end
    if (a_if.pkt_type_out !== 3'b000) begin errors++; $display("FAIL reset_pkt_type: got %0b exp 000", a_if.pkt_type_out); end
    if (a_if.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %0b exp 0", a_if.resp_valid); end
    if (a_if.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b exp 0", a_if.err); end
  endtask

  task automatic test_read();
    logic [511:0] d;
    do_reset();
    d = {64{8'hA5}};
    drive_a(1, 0, 36'h0_0000_1000, '0, 3'b000, '0, '0);
    tick();
    checks += 4;
    if (a_if.pkt_type_out !== 3'b011) begin errors++; $display("FAIL read_pkt_type: got %0b exp 011", a_if.pkt_type_out); end
    if (a_if.pkt_id_out !== 4'd0) begin errors++; $display("FAIL read_pkt_id: got %0d exp 0", a_if.pkt_id_out); end
    if (a_if.pkt_addr_out !== 36'h1000) begin errors++; $display("FAIL read_pkt_addr: got %0h exp 1000", a_if.pkt_addr_out); end
    if (a_if.outstanding !== 5'd1) begin errors++; $display("FAIL read_outstanding1: got %0d exp 1", a_if.outstanding); end
    drive_a(0, 0, '0, '0, 3'b110, 4'd0, d);
    tick();
    checks += 7;
    if (a_if.pkt_type_out !== 3'b000) begin errors++; $display("FAIL read_pkt_idle: got %0b exp 000", a_if.pkt_type_out); end
    if (a_if.resp_valid !== 1'b1) begin errors++; $display("FAIL read_resp_valid: got %0b exp 1", a_if.resp_valid); end
    if (a_if.resp_id !== 4'd0) begin errors++; $display("FAIL read_resp_id: got %0d exp 0", a_if.resp_id); end
    if (a_if.resp_we !== 1'b0) begin errors++; $display("FAIL read_resp_we: got %0b exp 0", a_if.resp_we); end
    if (a_if.resp_data !== d) begin errors++; $display("FAIL read_resp_data: got %0h exp %0h", a_if.resp_data, d); end
    if (a_if.resp_addr !== 36'h1000) begin errors++; $display("FAIL read_resp_addr: got %0h exp 1000", a_if.resp_addr); end
    if (a_if.outstanding !== 5'd0) begin errors++; $display("FAIL read_outstanding0: got %0d exp 0", a_if.outstanding); end
    drive_a(0, 0, '0, '0, 3'b000, '0, '0);
    tick();
    checks++;
    if (a_if.resp_valid !== 1'b0) begin errors++; $display("FAIL read_resp_strobe: got %0b exp 0", a_if.resp_valid); end
  endtask

  task automatic test_write();
    do_reset();
    drive_a(1, 1, 36'h40, 512'h1234, 3'b000, '0, '0);
    tick();
    checks += 4;
    if (a_if.pkt_type_out !== 3'b001) begin errors++; $display("FAIL write_pkt_type: got %0b exp 001", a_if.pkt_type_out); end
    if (a_if.pkt_id_out !== 4'd0) begin errors++; $display("FAIL write_pkt_id: got %0d exp 0", a_if.pkt_id_out); end
    if (a_if.pkt_addr_out !== 36'h40) begin errors++; $display("FAIL write_pkt_addr: got %0h exp 40", a_if.pkt_addr_out); end
    if (a_if.pkt_data_out !== 512'h1234) begin errors++; $display("FAIL write_pkt_data: got %0h exp 1234", a_if.pkt_data_out); end
    drive_a(0, 0, '0, '0, 3'b101, 4'd0, {16{32'hDEADBEEF}});
    tick();
    checks += 5;
    if (a_if.resp_valid !== 1'b1) begin errors++; $display("FAIL write_resp_valid: got %0b exp 1", a_if.resp_valid); end
    if (a_if.resp_we !== 1'b1) begin errors++; $display("FAIL write_resp_we: got %0b exp 1", a_if.resp_we); end
    if (a_if.resp_data !== '0) begin errors++; $display("FAIL write_resp_data: got %0h exp 0", a_if.resp_data); end
    if (a_if.resp_addr !== 36'h40) begin errors++; $display("FAIL write_resp_addr: got %0h exp 40", a_if.resp_addr); end
    if (a_if.outstanding !== 5'd0) begin errors++; $display("FAIL write_freed: got %0d exp 0", a_if.outstanding); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive_a(1, 0, 36'(i * 64), '0, 3'b000, '0, '0);
      checks += 2;
      if (a_if.req_ready !== 1'b1) begin errors++; $display("FAIL full_ready_%0d: got %0b exp 1", i, a_if.req_ready); end
      if (a_if.req_id !== 4'(i)) begin errors++; $display("FAIL full_id_%0d: got %0d exp %0d", i, a_if.req_id, i); end
      tick();
    end
    drive_a(1, 0, 36'h999, '0, 3'b000, '0, '0);
    checks += 2;
    if (a_if.outstanding !== 5'd16) begin errors++; $display("FAIL full_outstanding: got %0d exp 16", a_if.outstanding); end
    if (a_if.req_ready !== 1'b0) begin errors++; $display("FAIL full_not_ready: got %0b exp 0", a_if.req_ready); end
    drive_a(1, 0, 36'h999, '0, 3'b110, 4'd0, 512'h77);
    tick();
    checks += 4;
    if (a_if.pkt_type_out !== 3'b000) begin errors++; $display("FAIL full_no_accept: got %0b exp 000", a_if.pkt_type_out); end
    if (a_if.resp_valid !== 1'b1) begin errors++; $display("FAIL full_resp_valid: got %0b exp 1", a_if.resp_valid); end
    if (a_if.req_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after_free: got %0b exp 1", a_if.req_ready); end
    if (a_if.outstanding !== 5'd15) begin errors++; $display("FAIL full_outstanding15: got %0d exp 15", a_if.outstanding); end
    drive_a(1, 0, 36'h999, '0, 3'b000, '0, '0);
    tick();
    checks += 3;
    if (a_if.pkt_id_out !== 4'd0) begin errors++; $display("FAIL full_17th_id: got %0d exp 0", a_if.pkt_id_out); end
    if (a_if.pkt_addr_out !== 36'h999) begin errors++; $display("FAIL full_17th_addr: got %0h exp 999", a_if.pkt_addr_out); end
    if (a_if.outstanding !== 5'd16) begin errors++; $display("FAIL full_refill: got %0d exp 16", a_if.outstanding); end
  endtask

  task automatic test_multibeat();
    logic [127:0] d;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_b(1, 36'(16'h100 + i), 3'b000, '0, '0);
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      drive_b(0, '0, 3'b110, 4'd3, d);
      tick();
      checks += 5;
      if (b_if.resp_valid !== 1'b1) begin errors++; $display("FAIL beat%0d_valid: got %0b exp 1", k, b_if.resp_valid); end
      if (b_if.resp_beat !== 2'(k)) begin errors++; $display("FAIL beat%0d_index: got %0d exp %0d", k, b_if.resp_beat, k); end
      if (b_if.resp_data !== d) begin errors++; $display("FAIL beat%0d_data: got %0h exp %0h", k, b_if.resp_data, d); end
      if (b_if.resp_addr !== 36'h103) begin errors++; $display("FAIL beat%0d_addr: got %0h exp 103", k, b_if.resp_addr); end
      if (b_if.outstanding !== ((k < 3) ? 5'd4 : 5'd3)) begin
        errors++; $display("FAIL beat%0d_outstanding: got %0d exp %0d", k, b_if.outstanding, (k < 3) ? 4 : 3);
      end
    end
    drive_b(0, '0, 3'b000, '0, '0);
  endtask

  task automatic test_errors();
    do_reset();
    drive_a(0, 0, '0, '0, 3'b011, 4'd0, '0);
    tick();
    drive_a(0, 0, '0, '0, 3'b111, 4'd0, '0);
    tick();
    checks++;
    if (a_if.err !== 1'b0) begin errors++; $display("FAIL err_ignored_types: got %0b exp 0", a_if.err); end
    drive_a(0, 0, '0, '0, 3'b110, 4'd5, 512'h5);
    tick();
    checks += 2;
    if (a_if.err !== 1'b1) begin errors++; $display("FAIL err_idle_id: got %0b exp 1", a_if.err); end
    if (a_if.resp_valid !== 1'b0) begin errors++; $display("FAIL err_idle_no_resp: got %0b exp 0", a_if.resp_valid); end
    drive_a(1, 0, 36'h80, '0, 3'b000, '0, '0);
    tick();
    drive_a(0, 0, '0, '0, 3'b101, 4'd0, '0);
    tick();
    checks += 3;
    if (a_if.err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %0b exp 1", a_if.err); end
    if (a_if.resp_valid !== 1'b0) begin errors++; $display("FAIL err_type_no_resp: got %0b exp 0", a_if.resp_valid); end
    if (a_if.outstanding !== 5'd1) begin errors++; $display("FAIL err_still_busy: got %0d exp 1", a_if.outstanding); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive_a(1, 0, 36'(32'h200 + i), '0, 3'b000, '0, '0);
      tick();
    end
    drive_a(0, 0, '0, '0, 3'b000, '0, '0);
    checks += 2;
    if (a_if.outstanding !== 5'd5) begin errors++; $display("FAIL mid_outstanding: got %0d exp 5", a_if.outstanding); end
    if (a_if.pkt_type_out !== 3'b011) begin errors++; $display("FAIL mid_pkt_pending: got %0b exp 011", a_if.pkt_type_out); end
    #1 rst = 1'b1;
    #1;
    checks += 2;
    if (a_if.outstanding !== 5'd0) begin errors++; $display("FAIL mid_async_outstanding: got %0d exp 0", a_if.outstanding); end
    if (a_if.pkt_type_out !== 3'b000) begin errors++; $display("FAIL mid_async_pkt: got %0b exp 000", a_if.pkt_type_out); end
    tick();
    rst = 1'b0;
    drive_a(1, 0, 36'h300, '0, 3'b000, '0, '0);
    checks++;
    if (a_if.req_id !== 4'd0) begin errors++; $display("FAIL mid_next_id: got %0d exp 0", a_if.req_id); end
    tick();
    drive_a(0, 0, '0, '0, 3'b110, 4'd2, 512'h1);
    tick();
    checks += 2;
    if (a_if.err !== 1'b1) begin errors++; $display("FAIL mid_stale_err: got %0b exp 1", a_if.err); end
    if (a_if.resp_valid !== 1'b0) begin errors++; $display("FAIL mid_stale_resp: got %0b exp 0", a_if.resp_valid); end
  endtask

  task automatic test_random();
    bit           m_busy [16];
    bit           m_we   [16];
    logic [35:0]  m_addr [16];
    int           m_next;
    bit           m_err;
    logic [2:0]   types  [6];
    logic         v, we;
    logic [35:0]  addr, e_addr;
    logic [511:0] data, rdata;
    logic [2:0]   rt;
    logic [3:0]   rid;
    bit           e_acc, e_rv, e_rwe;
    int           cnt, r;
    types = '{3'b000, 3'b001, 3'b011, 3'b101, 3'b110, 3'b111};
    do_reset();
    for (int i = 0; i < 16; i++) begin m_busy[i] = 0; m_we[i] = 0; m_addr[i] = '0; end
    m_next = 0;
    m_err  = 0;
    for (int c = 0; c < 400; c++) begin
      v    = ($urandom_range(0, 9) < 7);
      we   = $urandom_range(0, 1);
      addr = {$urandom, $urandom};
      for (int w = 0; w < 16; w++) begin
        data[w*32 +: 32]  = $urandom;
        rdata[w*32 +: 32] = $urandom;
      end
      rid = 4'($urandom_range(0, 15));
      r   = $urandom_range(0, 9);
      if (r < 5 && m_busy[rid]) rt = m_we[rid] ? 3'b101 : 3'b110;
      else if (r < 7) rt = types[$urandom_range(0, 5)];
      else rt = 3'b000;
      drive_a(v, we, addr, data, rt, rid, rdata);
      cnt = 0;
      for (int i = 0; i < 16; i++) cnt += m_busy[i];
      checks += 3;
      if (a_if.req_ready !== !m_busy[m_next]) begin errors++; $display("FAIL rnd%0d_ready: got %0b exp %0b", c, a_if.req_ready, !m_busy[m_next]); end
      if (a_if.req_id !== 4'(m_next)) begin errors++; $display("FAIL rnd%0d_req_id: got %0d exp %0d", c, a_if.req_id, m_next); end
      if (a_if.outstanding !== 5'(cnt)) begin errors++; $display("FAIL rnd%0d_outstanding: got %0d exp %0d", c, a_if.outstanding, cnt); end
      e_acc  = v && !m_busy[m_next];
      e_rwe  = (rt == 3'b101);
      e_rv   = (rt == 3'b101 || rt == 3'b110) && m_busy[rid] && (m_we[rid] == e_rwe);
      e_addr = m_addr[rid];
      if ((rt == 3'b101 || rt == 3'b110) && !e_rv) m_err = 1;
      if (e_rv) m_busy[rid] = 0;
      tick();
      checks += 6;
      if (a_if.pkt_type_out !== (e_acc ? (we ? 3'b001 : 3'b011) : 3'b000)) begin
        errors++; $display("FAIL rnd%0d_pkt_type: got %0b acc %0b we %0b", c, a_if.pkt_type_out, e_acc, we);
      end
      if (a_if.pkt_id_out !== (e_acc ? 4'(m_next) : 4'd0)) begin errors++; $display("FAIL rnd%0d_pkt_id: got %0d exp %0d", c, a_if.pkt_id_out, e_acc ? m_next : 0); end
      if (a_if.pkt_addr_out !== (e_acc ? addr : 36'd0)) begin errors++; $display("FAIL rnd%0d_pkt_addr: got %0h", c, a_if.pkt_addr_out); end
      if (a_if.pkt_data_out !== (e_acc ? data : 512'd0)) begin errors++; $display("FAIL rnd%0d_pkt_data: mismatched payload", c); end
      if (a_if.resp_valid !== e_rv) begin errors++; $display("FAIL rnd%0d_resp_valid: got %0b exp %0b", c, a_if.resp_valid, e_rv); end
      if (a_if.err !== m_err) begin errors++; $display("FAIL rnd%0d_err: got %0b exp %0b", c, a_if.err, m_err); end
      if (e_rv) begin
        checks += 5;
        if (a_if.resp_we !== e_rwe) begin errors++; $display("FAIL rnd%0d_resp_we: got %0b exp %0b", c, a_if.resp_we, e_rwe); end
        if (a_if.resp_id !== rid) begin errors++; $display("FAIL rnd%0d_resp_id: got %0d exp %0d", c, a_if.resp_id, rid); end
        if (a_if.resp_addr !== e_addr) begin errors++; $display("FAIL rnd%0d_resp_addr: got %0h exp %0h", c, a_if.resp_addr, e_addr); end
        if (a_if.resp_data !== (e_rwe ? 512'd0 : rdata)) begin errors++; $display("FAIL rnd%0d_resp_data: mismatched payload", c); end
        if (a_if.resp_beat !== 2'd0) begin errors++; $display("FAIL rnd%0d_resp_beat: got %0d exp 0", c, a_if.resp_beat); end
      end
      if (e_acc) begin
        m_busy[m_next] = 1;
        m_we[m_next]   = we;
        m_addr[m_next] = addr;
        m_next         = (m_next + 1) % 16;
      end
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_full();
    test_multibeat();
    test_errors();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
